// File: rtl/alu_seq.sv
// Four-phase sequencer for an 8-bit file-register ALU: decodes, captures, writes back, commits flags.
// Optional skip-on-zero for INCFSZ/DECFSZ is enabled by defining ALU_SEQ_SKIP_EN.
module alu_seq (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] op,
  input  logic       dest,
  output logic       ready,
  output logic       clr,
  output logic       swap_n_mov,
  output logic       rlf_n_rrf,
  output logic [1:0] op_mux_l,
  output logic [1:0] op_mux_a,
  output logic       sub,
  output logic [1:0] out_mux,
  output logic       C_in,
  input  logic [7:0] alu_out,
  input  logic       C_new,
  input  logic       DC_new,
  input  logic       Z_new,
  output logic [7:0] wb_data,
  output logic       w_we,
  output logic       f_we,
  output logic       c_flag,
  output logic       dc_flag,
  output logic       z_flag,
  output logic       skip,
  output logic       done
);

  localparam logic [3:0] OP_MOVF   = 4'd0;
  localparam logic [3:0] OP_SWAPF  = 4'd1;
  localparam logic [3:0] OP_RLF    = 4'd2;
  localparam logic [3:0] OP_RRF    = 4'd3;
  localparam logic [3:0] OP_IORWF  = 4'd4;
  localparam logic [3:0] OP_ANDWF  = 4'd5;
  localparam logic [3:0] OP_XORWF  = 4'd6;
  localparam logic [3:0] OP_COMF   = 4'd7;
  localparam logic [3:0] OP_ADDWF  = 4'd8;
  localparam logic [3:0] OP_SUBWF  = 4'd9;
  localparam logic [3:0] OP_INCF   = 4'd10;
  localparam logic [3:0] OP_DECF   = 4'd11;
  localparam logic [3:0] OP_CLRF   = 4'd12;
  localparam logic [3:0] OP_INCFSZ = 4'd13;
  localparam logic [3:0] OP_DECFSZ = 4'd14;
  localparam logic [3:0] OP_NOP    = 4'd15;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_Q1   = 3'd1,
    S_Q2   = 3'd2,
    S_Q3   = 3'd3,
    S_Q4   = 3'd4
  } state_e;

  typedef struct packed {
    logic       clr;
    logic       swap_n_mov;
    logic       rlf_n_rrf;
    logic [1:0] op_mux_l;
    logic [1:0] op_mux_a;
    logic       sub;
    logic [1:0] out_mux;
    logic       c_in;
  } ctrl_t;

  function automatic ctrl_t decode(input logic [3:0] o, input logic cin);
    ctrl_t c;
    c = '0;
    c.c_in = cin;
    case (o)
      OP_MOVF:   c.out_mux = 2'b00;
      OP_SWAPF:  c.swap_n_mov = 1'b1;
      OP_RLF: begin
        c.out_mux   = 2'b01;
        c.rlf_n_rrf = 1'b1;
      end
      OP_RRF:    c.out_mux = 2'b01;
      OP_IORWF:  c.out_mux = 2'b10;
      OP_ANDWF: begin
        c.out_mux  = 2'b10;
        c.op_mux_l = 2'd1;
      end
      OP_XORWF: begin
        c.out_mux  = 2'b10;
        c.op_mux_l = 2'd2;
      end
      OP_COMF: begin
        c.out_mux  = 2'b10;
        c.op_mux_l = 2'd3;
      end
      OP_ADDWF:  c.out_mux = 2'b11;
      OP_SUBWF: begin
        c.out_mux  = 2'b11;
        c.op_mux_a = 2'd1;
        c.sub      = 1'b1;
      end
      OP_INCF, OP_INCFSZ: begin
        c.out_mux  = 2'b11;
        c.op_mux_a = 2'd2;
      end
      OP_DECF, OP_DECFSZ: begin
        c.out_mux  = 2'b11;
        c.op_mux_a = 2'd3;
        c.sub      = 1'b1;
      end
      OP_CLRF:   c.clr = 1'b1;
      default:   c = '0;
    endcase
    return c;
  endfunction

  state_e     state_q, state_d;
  ctrl_t      ctrl_q, ctrl_d;
  logic [3:0] op_q, op_d;
  logic       dest_q, dest_d;
  logic [7:0] wb_q, wb_d;
  logic       sh_c_q, sh_c_d;
  logic       sh_dc_q, sh_dc_d;
  logic       sh_z_q, sh_z_d;
  logic       c_q, c_d;
  logic       dc_q, dc_d;
  logic       z_q, z_d;
  logic       w_we_q, w_we_d;
  logic       f_we_q, f_we_d;
  logic       done_q, done_d;
  logic       skip_q, skip_d;

  logic       upd_z;
  logic       upd_c;
  logic       upd_dc;
  logic       skip_op;

  // Which flags the latched opcode is allowed to commit
  always_comb begin
    upd_z   = 1'b0;
    upd_c   = 1'b0;
    upd_dc  = 1'b0;
    skip_op = 1'b0;
    case (op_q)
      OP_MOVF, OP_IORWF, OP_ANDWF, OP_XORWF,
      OP_COMF, OP_INCF, OP_DECF, OP_CLRF:
        upd_z = 1'b1;
      OP_RLF, OP_RRF:
        upd_c = 1'b1;
      OP_ADDWF, OP_SUBWF: begin
        upd_z  = 1'b1;
        upd_c  = 1'b1;
        upd_dc = 1'b1;
      end
      OP_INCFSZ, OP_DECFSZ: begin
`ifdef ALU_SEQ_SKIP_EN
        skip_op = 1'b1;
`else
        upd_z   = 1'b1;
`endif
      end
      default: ;
    endcase
  end

  // Phase sequencing: one state per cycle, start only honoured in IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_Q1;
      S_Q1:    state_d = S_Q2;
      S_Q2:    state_d = S_Q3;
      S_Q3:    state_d = S_Q4;
      S_Q4:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Controls, result capture, strobes and flag commit per phase
  always_comb begin
    ctrl_d  = ctrl_q;
    op_d    = op_q;
    dest_d  = dest_q;
    wb_d    = wb_q;
    sh_c_d  = sh_c_q;
    sh_dc_d = sh_dc_q;
    sh_z_d  = sh_z_q;
    c_d     = c_q;
    dc_d    = dc_q;
    z_d     = z_q;
    w_we_d  = 1'b0;
    f_we_d  = 1'b0;
    done_d  = 1'b0;
    skip_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        ctrl_d = '0;
        if (start) begin
          op_d   = op;
          dest_d = dest;
          ctrl_d = decode(op, c_q);
        end
      end
      S_Q2: begin
        wb_d    = alu_out;
        sh_c_d  = C_new;
        sh_dc_d = DC_new;
        sh_z_d  = Z_new;
        w_we_d  = (op_q != OP_NOP) && !dest_q;
        f_we_d  = (op_q != OP_NOP) && dest_q;
      end
      S_Q3: begin
        ctrl_d = '0;
        done_d = 1'b1;
        skip_d = skip_op && (wb_q == 8'h00);
      end
      S_Q4: begin
        if (upd_z)  z_d  = (op_q == OP_CLRF) ? 1'b1 : sh_z_q;
        if (upd_c)  c_d  = sh_c_q;
        if (upd_dc) dc_d = sh_dc_q;
      end
      default: ;
    endcase
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ctrl_q  <= '0;
      op_q    <= 4'd0;
      dest_q  <= 1'b0;
      wb_q    <= 8'h00;
      sh_c_q  <= 1'b0;
      sh_dc_q <= 1'b0;
      sh_z_q  <= 1'b0;
      c_q     <= 1'b0;
      dc_q    <= 1'b0;
      z_q     <= 1'b0;
      w_we_q  <= 1'b0;
      f_we_q  <= 1'b0;
      done_q  <= 1'b0;
      skip_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      op_q    <= op_d;
      dest_q  <= dest_d;
      wb_q    <= wb_d;
      sh_c_q  <= sh_c_d;
      sh_dc_q <= sh_dc_d;
      sh_z_q  <= sh_z_d;
      c_q     <= c_d;
      dc_q    <= dc_d;
      z_q     <= z_d;
      w_we_q  <= w_we_d;
      f_we_q  <= f_we_d;
      done_q  <= done_d;
      skip_q  <= skip_d;
    end
  end

  assign ready      = (state_q == S_IDLE);
  assign clr        = ctrl_q.clr;
  assign swap_n_mov = ctrl_q.swap_n_mov;
  assign rlf_n_rrf  = ctrl_q.rlf_n_rrf;
  assign op_mux_l   = ctrl_q.op_mux_l;
  assign op_mux_a   = ctrl_q.op_mux_a;
  assign sub        = ctrl_q.sub;
  assign out_mux    = ctrl_q.out_mux;
  assign C_in       = ctrl_q.c_in;
  assign wb_data    = wb_q;
  assign w_we       = w_we_q;
  assign f_we       = f_we_q;
  assign c_flag     = c_q;
  assign dc_flag    = dc_q;
  assign z_flag     = z_q;
  assign done       = done_q;
`ifdef ALU_SEQ_SKIP_EN
  assign skip       = skip_q;
`else
  assign skip       = 1'b0;
`endif

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: drives ALU result inputs by hand per scenario.
// Covers reset, decode, capture, strobes, flag commit, start masking and skip.
module tb_alu_seq;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] op;
  logic       dest;
  logic       ready;
  logic       clr;
  logic       swap_n_mov;
  logic       rlf_n_rrf;
  logic [1:0] op_mux_l;
  logic [1:0] op_mux_a;
  logic       sub;
  logic [1:0] out_mux;
  logic       C_in;
  logic [7:0] alu_out;
  logic       C_new;
  logic       DC_new;
  logic       Z_new;
  logic [7:0] wb_data;
  logic       w_we;
  logic       f_we;
  logic       c_flag;
  logic       dc_flag;
  logic       z_flag;
  logic       skip;
  logic       done;

  int errors = 0;
  int checks = 0;

  alu_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .dest(dest),
    .ready(ready), .clr(clr), .swap_n_mov(swap_n_mov),
    .rlf_n_rrf(rlf_n_rrf), .op_mux_l(op_mux_l), .op_mux_a(op_mux_a),
    .sub(sub), .out_mux(out_mux), .C_in(C_in), .alu_out(alu_out),
    .C_new(C_new), .DC_new(DC_new), .Z_new(Z_new), .wb_data(wb_data),
    .w_we(w_we), .f_we(f_we), .c_flag(c_flag), .dc_flag(dc_flag),
    .z_flag(z_flag), .skip(skip), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    op = 4'd0;
    dest = 1'b0;
    alu_out = 8'h00;
    C_new = 1'b0;
    DC_new = 1'b0;
    Z_new = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    checks++;
    if (ready !== 1'b1) begin errors++; $display("FAIL rst_ready got=%b exp=1", ready); end
    checks++;
    if ({c_flag, dc_flag, z_flag} !== 3'b000) begin
      errors++; $display("FAIL rst_flags got=%b exp=000", {c_flag, dc_flag, z_flag});
    end
    checks++;
    if (wb_data !== 8'h00) begin errors++; $display("FAIL rst_wb got=%h exp=00", wb_data); end
    checks++;
    if ({done, w_we, f_we, skip, out_mux, C_in} !== 7'd0) begin
      errors++; $display("FAIL rst_outs got=%b exp=0", {done, w_we, f_we, skip, out_mux, C_in});
    end
  endtask

  task automatic test_addwf();
    op = 4'd8; dest = 1'b1;
    alu_out = 8'h00; C_new = 1'b1; DC_new = 1'b0; Z_new = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if ({out_mux, op_mux_a, sub} !== 5'b11000) begin
      errors++; $display("FAIL add_ctrl_q1 got=%b exp=11000", {out_mux, op_mux_a, sub});
    end
    tick();
    checks++;
    if (out_mux !== 2'b11) begin errors++; $display("FAIL add_ctrl_q2 got=%b exp=11", out_mux); end
    tick();
    checks++;
    if ({f_we, w_we} !== 2'b10) begin
      errors++; $display("FAIL add_we_q3 got=%b exp=10", {f_we, w_we});
    end
    checks++;
    if (wb_data !== 8'h00) begin errors++; $display("FAIL add_wb got=%h exp=00", wb_data); end
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL add_done_early got=%b exp=0", done); end
    tick();
    checks++;
    if ({done, skip, f_we} !== 3'b100) begin
      errors++; $display("FAIL add_done_q4 got=%b exp=100", {done, skip, f_we});
    end
    checks++;
    if (out_mux !== 2'b00) begin errors++; $display("FAIL add_ctrl_q4 got=%b exp=00", out_mux); end
    tick();
    checks++;
    if ({c_flag, dc_flag, z_flag} !== 3'b101) begin
      errors++; $display("FAIL add_flags got=%b exp=101", {c_flag, dc_flag, z_flag});
    end
    checks++;
    if ({ready, done} !== 2'b10) begin
      errors++; $display("FAIL add_idle got=%b exp=10", {ready, done});
    end
  endtask

  task automatic test_rlf();
    op = 4'd2; dest = 1'b0;
    alu_out = 8'h01; C_new = 1'b1; DC_new = 1'b0; Z_new = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if ({out_mux, rlf_n_rrf} !== 3'b011) begin
      errors++; $display("FAIL rlf_ctrl got=%b exp=011", {out_mux, rlf_n_rrf});
    end
    for (int i = 1; i <= 3; i++) begin
      checks++;
      if (C_in !== 1'b1) begin errors++; $display("FAIL rlf_cin_q%0d got=%b exp=1", i, C_in); end
      if (i < 3) tick();
    end
    checks++;
    if ({w_we, f_we, wb_data} !== {2'b10, 8'h01}) begin
      errors++; $display("FAIL rlf_q3 got=%b_%h exp=10_01", {w_we, f_we}, wb_data);
    end
    tick();
    checks++;
    if (C_in !== 1'b0) begin errors++; $display("FAIL rlf_cin_q4 got=%b exp=0", C_in); end
    tick();
    checks++;
    if ({c_flag, dc_flag, z_flag} !== 3'b101) begin
      errors++; $display("FAIL rlf_flags got=%b exp=101", {c_flag, dc_flag, z_flag});
    end
  endtask

  task automatic test_start_ignored();
    int dones;
    dones = 0;
    op = 4'd1; dest = 1'b1;
    alu_out = 8'h10; C_new = 1'b0; DC_new = 1'b1; Z_new = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if ({swap_n_mov, out_mux} !== 3'b100) begin
      errors++; $display("FAIL swap_ctrl got=%b exp=100", {swap_n_mov, out_mux});
    end
    tick();
    start = 1'b1;
    op = 4'd8;
    tick();
    start = 1'b0;
    if (done === 1'b1) dones++;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done === 1'b1) dones++;
    end
    checks++;
    if (dones !== 1) begin errors++; $display("FAIL swap_dones got=%0d exp=1", dones); end
    checks++;
    if ({c_flag, dc_flag, z_flag} !== 3'b101) begin
      errors++; $display("FAIL swap_flags got=%b exp=101", {c_flag, dc_flag, z_flag});
    end
  endtask

  task automatic test_nop();
    int wes;
    wes = 0;
    op = 4'd15; dest = 1'b1;
    alu_out = 8'hAA; C_new = 1'b0; DC_new = 1'b1; Z_new = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if ({clr, swap_n_mov, rlf_n_rrf, op_mux_l, op_mux_a, sub, out_mux} !== 10'd0) begin
      errors++; $display("FAIL nop_ctrl got=%b exp=0", {out_mux, op_mux_l, op_mux_a});
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      if (w_we === 1'b1 || f_we === 1'b1) wes++;
    end
    checks++;
    if (wes !== 0) begin errors++; $display("FAIL nop_we got=%0d exp=0", wes); end
    checks++;
    if ({c_flag, dc_flag, z_flag} !== 3'b101) begin
      errors++; $display("FAIL nop_flags got=%b exp=101", {c_flag, dc_flag, z_flag});
    end
  endtask

  task automatic test_reset_mid();
    int wes;
    wes = 0;
    op = 4'd8; dest = 1'b0;
    alu_out = 8'h7F; C_new = 1'b1; DC_new = 1'b1; Z_new = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++;
    if (ready !== 1'b1) begin errors++; $display("FAIL rmid_ready got=%b exp=1", ready); end
    checks++;
    if ({c_flag, dc_flag, z_flag, wb_data} !== 11'd0) begin
      errors++; $display("FAIL rmid_state got=%b_%h exp=000_00", {c_flag, dc_flag, z_flag}, wb_data);
    end
    if (w_we === 1'b1 || f_we === 1'b1) wes++;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (w_we === 1'b1 || f_we === 1'b1 || done === 1'b1) wes++;
    end
    checks++;
    if (wes !== 0) begin errors++; $display("FAIL rmid_strobes got=%0d exp=0", wes); end
  endtask

  task automatic test_decfsz();
    op = 4'd14; dest = 1'b1;
    alu_out = 8'h00; C_new = 1'b1; DC_new = 1'b1; Z_new = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if ({out_mux, op_mux_a, sub} !== 5'b11111) begin
      errors++; $display("FAIL dsz_ctrl got=%b exp=11111", {out_mux, op_mux_a, sub});
    end
    tick();
    tick();
    tick();
`ifdef ALU_SEQ_SKIP_EN
    checks++;
    if ({done, skip} !== 2'b11) begin errors++; $display("FAIL dsz_skip got=%b exp=11", {done, skip}); end
    tick();
    checks++;
    if ({c_flag, dc_flag, z_flag, skip} !== 4'b0000) begin
      errors++; $display("FAIL dsz_flags got=%b exp=0000", {c_flag, dc_flag, z_flag, skip});
    end
`else
    checks++;
    if ({done, skip} !== 2'b10) begin errors++; $display("FAIL dsz_skip got=%b exp=10", {done, skip}); end
    tick();
    checks++;
    if ({c_flag, dc_flag, z_flag, skip} !== 4'b0010) begin
      errors++; $display("FAIL dsz_flags got=%b exp=0010", {c_flag, dc_flag, z_flag, skip});
    end
`endif
  endtask

  task automatic test_back_to_back();
    int first;
    int second;
    int n;
    first = -1;
    second = -1;
    op = 4'd10; dest = 1'b0;
    alu_out = 8'h05; C_new = 1'b1; DC_new = 1'b1; Z_new = 1'b0;
    start = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (done === 1'b1) begin
        if (first < 0) first = i;
        else if (second < 0) second = i;
      end
    end
    start = 1'b0;
    checks++;
    if (first !== 4) begin errors++; $display("FAIL b2b_latency got=%0d exp=4", first); end
    checks++;
    if (second - first !== 5) begin
      errors++; $display("FAIL b2b_period got=%0d exp=5", second - first);
    end
    n = 0;
    while (ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (ready !== 1'b1) begin errors++; $display("FAIL b2b_drain got=%b exp=1", ready); end
    checks++;
    if ({wb_data, z_flag} !== {8'h05, 1'b0}) begin
      errors++; $display("FAIL b2b_result got=%h_%b exp=05_0", wb_data, z_flag);
    end
  endtask

  initial begin
    test_reset();
    test_addwf();
    test_rlf();
    test_start_ignored();
    test_nop();
    test_reset_mid();
    test_decfsz();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
